// File: rtl/store_narrow_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Package : cpu_mem_pkg
//  Shared types and byte-enable constants for the store narrowing path.
//  Revision: 1.0 - initial release
// ============================================================================
package cpu_mem_pkg;

  typedef enum logic {SZ_BYTE, SZ_HALF} store_size_e;

  typedef enum logic [1:0] {IDLE, BEAT1, BEAT2} state_e;

  localparam logic [1:0] BE_LO  = 2'b01;
  localparam logic [1:0] BE_HI  = 2'b10;
  localparam logic [1:0] BE_ALL = 2'b11;

endpackage
`default_nettype wire

// File: rtl/store_narrow_unit_if.sv
`default_nettype none
// ============================================================================
//  Interface : store_narrow_unit_if
//  Request (EX/MEM side) and data-memory write port of the store unit.
//  master = requester/memory environment, slave = the store unit itself.
//  Revision: 1.0 - initial release
// ============================================================================
interface store_narrow_unit_if
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W = 16
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [15:0]       req_data;
  store_size_e       req_size;
  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic [1:0]        mem_be;
  logic              done;
  logic              err_misalign;

  modport master (
    output req_valid, req_addr, req_data, req_size, mem_ready,
    input  req_ready, mem_valid, mem_addr, mem_wdata, mem_be, done, err_misalign
  );

  modport slave (
    input  req_valid, req_addr, req_data, req_size, mem_ready,
    output req_ready, mem_valid, mem_addr, mem_wdata, mem_be, done, err_misalign
  );
endinterface
`default_nettype wire

// File: rtl/store_narrow_unit_lane_align.sv
`default_nettype none
// ============================================================================
//  Module  : store_lane_align
//  Maps a store value onto the 16-bit memory lanes and builds byte enables.
//  beat_sel=1 selects the second beat of a split halfword (upper byte into
//  the even lane). Disabled lanes are driven to zero.
//  Revision: 1.0 - initial release
// ============================================================================
module store_lane_align
  import cpu_mem_pkg::*;
(
  input  store_size_e size,
  input  logic        addr0,
  input  logic [15:0] data,
  input  logic        beat_sel,
  output logic [15:0] wdata,
  output logic [1:0]  be
);

  // Lane steering for byte, aligned half, and both halves of a split half
  always_comb begin
    wdata = 16'h0000;
    be    = 2'b00;
    if (beat_sel) begin
      be    = BE_LO;
      wdata = {8'h00, data[15:8]};
    end else if (addr0) begin
      // odd byte, or first beat of a misaligned half: low byte to odd lane
      be    = BE_HI;
      wdata = {data[7:0], 8'h00};
    end else if (size == SZ_HALF) begin
      be    = BE_ALL;
      wdata = data;
    end else begin
      be    = BE_LO;
      wdata = {8'h00, data[7:0]};
    end
  end

endmodule
`default_nettype wire

// File: rtl/store_narrow_unit.sv
`default_nettype none
// ============================================================================
//  Module  : store_narrow_unit
//  Narrows a 16-bit register value to a byte/halfword store on a byte-enabled
//  16-bit memory port. Misaligned halfwords are split into two little-endian
//  byte beats (ALLOW_SPLIT=1) or rejected with err_misalign (ALLOW_SPLIT=0).
//  Revision: 1.0 - initial release
// ============================================================================
module store_narrow_unit
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter bit ALLOW_SPLIT = 1'b1
)(
  input  logic                clk,
  input  logic                rst_n,
  store_narrow_unit_if.slave  bus
);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_BEAT1 = BEAT1;
  localparam logic [1:0] ST_BEAT2 = BEAT2;

  logic [1:0]        r_state;
  logic              r_mem_valid;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [15:0]       r_mem_wdata;
  logic [1:0]        r_mem_be;
  logic              r_done;
  logic              r_err;
  logic              r_split;
  logic [7:0]        r_hi_byte;

  logic              w_accept;
  logic              w_misalign_half;
  logic              w_reject;
  logic              w_al_beat2;
  store_size_e       w_al_size;
  logic              w_al_addr0;
  logic [15:0]       w_al_data;
  logic [15:0]       w_al_wdata;
  logic [1:0]        w_al_be;

  assign w_accept        = bus.req_valid & (r_state == ST_IDLE);
  assign w_misalign_half = (bus.req_size == SZ_HALF) & bus.req_addr[0];

  generate
    if (ALLOW_SPLIT) begin : g_split_on
      assign w_reject = 1'b0;
    end else begin : g_split_off
      assign w_reject = w_misalign_half;
    end
  endgenerate

  // The aligner sees the live request in IDLE and the latched upper byte in BEAT1,
  // so beat-2 fields are ready to load on the beat-1 handshake edge.
  assign w_al_beat2 = (r_state == ST_BEAT1);
  assign w_al_size  = w_al_beat2 ? SZ_HALF : bus.req_size;
  assign w_al_addr0 = w_al_beat2 ? 1'b1 : bus.req_addr[0];
  assign w_al_data  = w_al_beat2 ? {r_hi_byte, 8'h00} : bus.req_data;

  store_lane_align u_align (
    .size     (w_al_size),
    .addr0    (w_al_addr0),
    .data     (w_al_data),
    .beat_sel (w_al_beat2),
    .wdata    (w_al_wdata),
    .be       (w_al_be)
  );

  // Store FSM and registered memory-port outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_mem_valid <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= 16'h0000;
      r_mem_be    <= 2'b00;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_split     <= 1'b0;
      r_hi_byte   <= 8'h00;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (w_reject) begin
              r_err <= 1'b1;
            end else begin
              r_mem_valid <= 1'b1;
              r_mem_addr  <= {bus.req_addr[ADDR_W-1:1], 1'b0};
              r_mem_wdata <= w_al_wdata;
              r_mem_be    <= w_al_be;
              r_split     <= w_misalign_half;
              r_hi_byte   <= bus.req_data[15:8];
              r_state     <= ST_BEAT1;
            end
          end
        end
        ST_BEAT1: begin
          if (bus.mem_ready) begin
            if (r_split) begin
              // beat1 addr is a&~1 with a odd, so (a+1)&~1 is simply +2 (wraps)
              r_mem_addr  <= r_mem_addr + ADDR_W'(2);
              r_mem_wdata <= w_al_wdata;
              r_mem_be    <= w_al_be;
              r_state     <= ST_BEAT2;
            end else begin
              r_mem_valid <= 1'b0;
              r_done      <= 1'b1;
              r_state     <= ST_IDLE;
            end
          end
        end
        ST_BEAT2: begin
          if (bus.mem_ready) begin
            r_mem_valid <= 1'b0;
            r_done      <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_mem_valid <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready    = (r_state == ST_IDLE);
  assign bus.mem_valid    = r_mem_valid;
  assign bus.mem_addr     = r_mem_addr;
  assign bus.mem_wdata    = r_mem_wdata;
  assign bus.mem_be       = r_mem_be;
  assign bus.done         = r_done;
  assign bus.err_misalign = r_err;

endmodule
`default_nettype wire

// File: tb/tb_store_narrow_unit.sv
`default_nettype none
// ============================================================================
//  Module  : tb_store_narrow_unit
//  Directed self-checking bench for store_narrow_unit (split and reject builds).
//  Revision: 1.0 - initial release
// ============================================================================
module tb_store_narrow_unit;
  import cpu_mem_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  store_narrow_unit_if #(.ADDR_W(16)) if_s ();
  store_narrow_unit_if #(.ADDR_W(16)) if_n ();

  store_narrow_unit #(.ADDR_W(16), .ALLOW_SPLIT(1'b1)) dut_s (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_s.slave)
  );

  store_narrow_unit #(.ADDR_W(16), .ALLOW_SPLIT(1'b0)) dut_n (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_n.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive_s(input logic [15:0] a, input logic [15:0] d, input store_size_e sz);
    if_s.req_valid = 1'b1;
    if_s.req_addr  = a;
    if_s.req_data  = d;
    if_s.req_size  = sz;
  endtask

  task automatic test_reset;
    if_s.req_valid = 1'b0; if_s.req_addr = '0; if_s.req_data = '0;
    if_s.req_size  = SZ_BYTE; if_s.mem_ready = 1'b0;
    if_n.req_valid = 1'b0; if_n.req_addr = '0; if_n.req_data = '0;
    if_n.req_size  = SZ_BYTE; if_n.mem_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({if_s.mem_valid, if_s.mem_addr, if_s.mem_wdata, if_s.mem_be, if_s.done, if_s.err_misalign} !== 37'd0) begin
      failures++;
      $display("FAIL reset_outputs: got v=%b a=%h w=%h be=%b d=%b e=%b want all zero",
               if_s.mem_valid, if_s.mem_addr, if_s.mem_wdata, if_s.mem_be, if_s.done, if_s.err_misalign);
    end
    checks++;
    if (if_s.req_ready !== 1'b1) begin
      failures++; $display("FAIL reset_ready: got %b want 1", if_s.req_ready);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_byte;
    drive_s(16'h0101, 16'hABCD, SZ_BYTE);
    if_s.mem_ready = 1'b1;
    @(posedge clk); #1;
    if_s.req_valid = 1'b0; if_s.req_data = 16'h0000;
    checks++;
    if ({if_s.mem_valid, if_s.mem_addr, if_s.mem_be, if_s.mem_wdata} !== {1'b1, 16'h0100, 2'b10, 16'hCD00}) begin
      failures++;
      $display("FAIL byte_beat: got v=%b a=%h be=%b w=%h want v=1 a=0100 be=10 w=CD00",
               if_s.mem_valid, if_s.mem_addr, if_s.mem_be, if_s.mem_wdata);
    end
    checks++;
    if (if_s.done !== 1'b0) begin failures++; $display("FAIL byte_done_early: got %b want 0", if_s.done); end
    @(posedge clk); #1;
    checks++;
    if ({if_s.done, if_s.mem_valid} !== 2'b10) begin
      failures++; $display("FAIL byte_done: got done=%b v=%b want done=1 v=0", if_s.done, if_s.mem_valid);
    end
    @(posedge clk); #1;
    checks++;
    if ({if_s.done, if_s.req_ready} !== 2'b01) begin
      failures++; $display("FAIL byte_done_pulse: got done=%b rdy=%b want done=0 rdy=1", if_s.done, if_s.req_ready);
    end
  endtask

  task automatic test_half_aligned;
    drive_s(16'h0200, 16'h1234, SZ_HALF);
    if_s.mem_ready = 1'b1;
    @(posedge clk); #1;
    if_s.req_valid = 1'b0;
    checks++;
    if ({if_s.mem_valid, if_s.mem_addr, if_s.mem_be, if_s.mem_wdata} !== {1'b1, 16'h0200, 2'b11, 16'h1234}) begin
      failures++;
      $display("FAIL half_beat: got v=%b a=%h be=%b w=%h want v=1 a=0200 be=11 w=1234",
               if_s.mem_valid, if_s.mem_addr, if_s.mem_be, if_s.mem_wdata);
    end
    @(posedge clk); #1;
    checks++;
    if ({if_s.done, if_s.mem_valid} !== 2'b10) begin
      failures++; $display("FAIL half_done: got done=%b v=%b want done=1 v=0", if_s.done, if_s.mem_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_split;
    drive_s(16'h0301, 16'hBEEF, SZ_HALF);
    if_s.mem_ready = 1'b1;
    @(posedge clk); #1;
    if_s.req_valid = 1'b0; if_s.req_data = 16'h0000;
    checks++;
    if ({if_s.mem_valid, if_s.mem_addr, if_s.mem_be, if_s.mem_wdata} !== {1'b1, 16'h0300, 2'b10, 16'hEF00}) begin
      failures++;
      $display("FAIL split_beat1: got v=%b a=%h be=%b w=%h want v=1 a=0300 be=10 w=EF00",
               if_s.mem_valid, if_s.mem_addr, if_s.mem_be, if_s.mem_wdata);
    end
    @(posedge clk); #1;
    checks++;
    if ({if_s.mem_valid, if_s.mem_addr, if_s.mem_be, if_s.mem_wdata, if_s.done} !== {1'b1, 16'h0302, 2'b01, 16'h00BE, 1'b0}) begin
      failures++;
      $display("FAIL split_beat2: got v=%b a=%h be=%b w=%h done=%b want v=1 a=0302 be=01 w=00BE done=0",
               if_s.mem_valid, if_s.mem_addr, if_s.mem_be, if_s.mem_wdata, if_s.done);
    end
    @(posedge clk); #1;
    checks++;
    if ({if_s.done, if_s.mem_valid} !== 2'b10) begin
      failures++; $display("FAIL split_done: got done=%b v=%b want done=1 v=0", if_s.done, if_s.mem_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_wrap_backpressure;
    drive_s(16'hFFFF, 16'h5A3C, SZ_HALF);
    if_s.mem_ready = 1'b0;
    @(posedge clk); #1;
    if_s.req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({if_s.mem_valid, if_s.mem_addr, if_s.mem_be, if_s.mem_wdata} !== {1'b1, 16'hFFFE, 2'b10, 16'h3C00}) begin
        failures++;
        $display("FAIL wrap_hold%0d: got v=%b a=%h be=%b w=%h want v=1 a=FFFE be=10 w=3C00",
                 i, if_s.mem_valid, if_s.mem_addr, if_s.mem_be, if_s.mem_wdata);
      end
      if (i == 2) if_s.mem_ready = 1'b1;
      @(posedge clk); #1;
    end
    checks++;
    if ({if_s.mem_valid, if_s.mem_addr, if_s.mem_be, if_s.mem_wdata} !== {1'b1, 16'h0000, 2'b01, 16'h005A}) begin
      failures++;
      $display("FAIL wrap_beat2: got v=%b a=%h be=%b w=%h want v=1 a=0000 be=01 w=005A",
               if_s.mem_valid, if_s.mem_addr, if_s.mem_be, if_s.mem_wdata);
    end
    @(posedge clk); #1;
    checks++;
    if ({if_s.done, if_s.mem_valid} !== 2'b10) begin
      failures++; $display("FAIL wrap_done: got done=%b v=%b want done=1 v=0", if_s.done, if_s.mem_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reject;
    if_n.req_valid = 1'b1; if_n.req_addr = 16'h0011; if_n.req_data = 16'h7788;
    if_n.req_size  = SZ_HALF; if_n.mem_ready = 1'b1;
    @(posedge clk); #1;
    if_n.req_valid = 1'b0;
    checks++;
    if ({if_n.err_misalign, if_n.mem_valid, if_n.req_ready} !== 3'b101) begin
      failures++;
      $display("FAIL reject_err: got err=%b v=%b rdy=%b want err=1 v=0 rdy=1",
               if_n.err_misalign, if_n.mem_valid, if_n.req_ready);
    end
    @(posedge clk); #1;
    checks++;
    if ({if_n.err_misalign, if_n.mem_valid, if_n.done} !== 3'b000) begin
      failures++;
      $display("FAIL reject_pulse: got err=%b v=%b done=%b want 0 0 0",
               if_n.err_misalign, if_n.mem_valid, if_n.done);
    end
    // an aligned half still goes through on the non-splitting build
    if_n.req_valid = 1'b1; if_n.req_addr = 16'h0040; if_n.req_data = 16'h7788;
    @(posedge clk); #1;
    if_n.req_valid = 1'b0;
    checks++;
    if ({if_n.mem_valid, if_n.mem_addr, if_n.mem_be, if_n.mem_wdata, if_n.err_misalign} !== {1'b1, 16'h0040, 2'b11, 16'h7788, 1'b0}) begin
      failures++;
      $display("FAIL reject_aligned: got v=%b a=%h be=%b w=%h err=%b want v=1 a=0040 be=11 w=7788 err=0",
               if_n.mem_valid, if_n.mem_addr, if_n.mem_be, if_n.mem_wdata, if_n.err_misalign);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    drive_s(16'h0010, 16'h0042, SZ_BYTE);
    if_s.mem_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({if_s.mem_valid, if_s.req_ready, if_s.mem_wdata} !== {1'b1, 1'b0, 16'h0042}) begin
      failures++;
      $display("FAIL b2b_first: got v=%b rdy=%b w=%h want v=1 rdy=0 w=0042",
               if_s.mem_valid, if_s.req_ready, if_s.mem_wdata);
    end
    drive_s(16'h0013, 16'h0099, SZ_BYTE);
    @(posedge clk); #1;
    checks++;
    if ({if_s.done, if_s.req_ready, if_s.mem_valid} !== 3'b110) begin
      failures++;
      $display("FAIL b2b_gap: got done=%b rdy=%b v=%b want 1 1 0", if_s.done, if_s.req_ready, if_s.mem_valid);
    end
    @(posedge clk); #1;
    if_s.req_valid = 1'b0;
    checks++;
    if ({if_s.mem_valid, if_s.mem_addr, if_s.mem_be, if_s.mem_wdata} !== {1'b1, 16'h0012, 2'b10, 16'h9900}) begin
      failures++;
      $display("FAIL b2b_second: got v=%b a=%h be=%b w=%h want v=1 a=0012 be=10 w=9900",
               if_s.mem_valid, if_s.mem_addr, if_s.mem_be, if_s.mem_wdata);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    drive_s(16'h0501, 16'hC3A5, SZ_HALF);
    if_s.mem_ready = 1'b1;
    @(posedge clk); #1;
    if_s.req_valid = 1'b0;
    @(posedge clk); #1;
    if_s.mem_ready = 1'b0;
    checks++;
    if ({if_s.mem_valid, if_s.mem_be} !== 3'b101) begin
      failures++; $display("FAIL rstmid_beat2: got v=%b be=%b want v=1 be=01", if_s.mem_valid, if_s.mem_be);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({if_s.mem_valid, if_s.mem_be, if_s.mem_addr} !== 19'd0) begin
      failures++;
      $display("FAIL rstmid_async: got v=%b be=%b a=%h want 0 00 0000", if_s.mem_valid, if_s.mem_be, if_s.mem_addr);
    end
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({if_s.req_ready, if_s.mem_valid} !== 2'b10) begin
      failures++; $display("FAIL rstmid_idle: got rdy=%b v=%b want 1 0", if_s.req_ready, if_s.mem_valid);
    end
    drive_s(16'h0600, 16'h1177, SZ_BYTE);
    if_s.mem_ready = 1'b1;
    @(posedge clk); #1;
    if_s.req_valid = 1'b0;
    checks++;
    if ({if_s.mem_valid, if_s.mem_addr, if_s.mem_be, if_s.mem_wdata} !== {1'b1, 16'h0600, 2'b01, 16'h0077}) begin
      failures++;
      $display("FAIL rstmid_store: got v=%b a=%h be=%b w=%h want v=1 a=0600 be=01 w=0077",
               if_s.mem_valid, if_s.mem_addr, if_s.mem_be, if_s.mem_wdata);
    end
    @(posedge clk); #1;
    checks++;
    if (if_s.done !== 1'b1) begin failures++; $display("FAIL rstmid_done: got %b want 1", if_s.done); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_byte();
    test_half_aligned();
    test_split();
    test_wrap_backpressure();
    test_reject();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
